// File: rtl/face_candidate_buffer.sv
// face_candidate_buffer: serialises multi-scale face hits into a FWFT FIFO
// and reports per-frame candidate counts to the OS side.
module face_candidate_buffer #(
  parameter int DATA_WIDTH_12 = 12,
  parameter int NUM_RESIZE    = 5,
  parameter int FIFO_DEPTH    = 16,
  parameter int ADDR_WIDTH    = 4
) (
  input  logic                     clk_fpga,
  input  logic                     reset_fpga,
  input  logic [NUM_RESIZE-1:0]    i_candidate,
  input  logic [DATA_WIDTH_12-1:0] i_ori_x,
  input  logic [DATA_WIDTH_12-1:0] i_ori_y,
  input  logic                     i_frame_end,
  input  logic                     i_rd_en,
  output logic                     o_busy,
  output logic                     o_valid,
  output logic [DATA_WIDTH_12-1:0] o_x,
  output logic [DATA_WIDTH_12-1:0] o_y,
  output logic [2:0]               o_scale,
  output logic [ADDR_WIDTH:0]      o_count,
  output logic                     o_full,
  output logic                     o_overflow,
  output logic [7:0]               o_drop_count,
  output logic                     o_frame_done,
  output logic [7:0]               o_frame_cand_count
);

  typedef enum logic {
    IDLE,
    SERIAL
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH_12-1:0] x;
    logic [DATA_WIDTH_12-1:0] y;
    logic [2:0]               k;
  } entry_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [NUM_RESIZE-1:0]    mask;
  logic [NUM_RESIZE-1:0]    mask_nxt;
  logic [DATA_WIDTH_12-1:0] lat_x;
  logic [DATA_WIDTH_12-1:0] lat_y;
  logic [2:0]               low_k;
  logic                     capture;
  logic                     push_req;
  logic                     last;

  entry_t                   mem [FIFO_DEPTH];
  logic [ADDR_WIDTH:0]      wr_ptr;
  logic [ADDR_WIDTH:0]      rd_ptr;
  logic                     full;
  logic                     empty;
  logic                     pop;
  logic                     wr_en;
  logic                     fifo_drop;
  entry_t                   head;

  logic [3:0]               drop_add;
  logic [8:0]               drop_sum;
  logic [7:0]               drop_cnt;
  logic                     ovf;
  logic [7:0]               frame_cnt;
  logic [7:0]               frame_inc;
  logic                     pend;
  logic                     close;

  function automatic logic [3:0] pop_cnt(
    input logic [NUM_RESIZE-1:0] v
  );
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < NUM_RESIZE; i++)
      n = n + {3'b0, v[i]};
    return n;
  endfunction

  // lowest set bit of the pending mask
  always_comb begin
    low_k = '0;
    for (int k = NUM_RESIZE - 1; k >= 0; k--)
      if (mask[k]) low_k = 3'(k);
  end

  // serialiser next state and push request
  always_comb begin
    state_nxt = state;
    mask_nxt  = mask;
    capture   = 1'b0;
    push_req  = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE: begin
        if (|i_candidate) begin
          capture   = 1'b1;
          mask_nxt  = i_candidate;
          state_nxt = SERIAL;
        end
      end
      SERIAL: begin
        push_req = 1'b1;
        mask_nxt = mask & ~(NUM_RESIZE'(1) << low_k);
        if (mask_nxt == '0) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  // serialiser state, mask and latched origin
  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      state <= IDLE;
      mask  <= '0;
      lat_x <= '0;
      lat_y <= '0;
    end else begin
      state <= state_nxt;
      mask  <= mask_nxt;
      if (capture) begin
        lat_x <= i_ori_x;
        lat_y <= i_ori_y;
      end
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign pop       = i_rd_en && !empty;
  assign wr_en     = push_req && (!full || pop);
  assign fifo_drop = push_req && full && !pop;

  // FIFO storage, no reset needed: read data gated by valid
  always_ff @(posedge clk_fpga) begin
    if (wr_en) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= '{x: lat_x, y: lat_y, k: low_k};
    end
  end

  // FIFO pointers
  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign drop_add = ((state == SERIAL) ? pop_cnt(i_candidate) : 4'd0)
                  + {3'b0, fifo_drop};
  assign drop_sum = {1'b0, drop_cnt} + {5'b0, drop_add};

  // sticky loss flag and saturating drop counter
  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      drop_cnt <= '0;
      ovf      <= 1'b0;
    end else if (drop_add != '0) begin
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      ovf      <= 1'b1;
    end
  end

  assign frame_inc = (wr_en && frame_cnt != 8'hFF)
                   ? frame_cnt + 8'd1 : frame_cnt;
  assign close = ((state == IDLE) && i_frame_end) ||
                 (last && (pend || i_frame_end));

  // frame accounting; a close during SERIAL waits for the mask to drain
  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      frame_cnt          <= '0;
      pend               <= 1'b0;
      o_frame_done       <= 1'b0;
      o_frame_cand_count <= '0;
    end else begin
      o_frame_done <= close;
      if (close) begin
        o_frame_cand_count <= frame_inc;
        frame_cnt          <= '0;
        pend               <= 1'b0;
      end else begin
        frame_cnt <= frame_inc;
        if (state == SERIAL && i_frame_end) pend <= 1'b1;
      end
    end
  end

  assign head         = mem[rd_ptr[ADDR_WIDTH-1:0]];
  assign o_busy       = (state == SERIAL);
  assign o_valid      = !empty;
  assign o_x          = empty ? '0 : head.x;
  assign o_y          = empty ? '0 : head.y;
  assign o_scale      = empty ? '0 : head.k;
  assign o_count      = wr_ptr - rd_ptr;
  assign o_full       = full;
  assign o_overflow   = ovf;
  assign o_drop_count = drop_cnt;

endmodule

// File: tb/tb_face_candidate_buffer.sv
// tb_face_candidate_buffer: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_face_candidate_buffer;

  logic        clk_fpga = 1'b0;
  logic        reset_fpga;
  logic [4:0]  i_candidate;
  logic [11:0] i_ori_x;
  logic [11:0] i_ori_y;
  logic        i_frame_end;
  logic        i_rd_en;
  logic        o_busy;
  logic        o_valid;
  logic [11:0] o_x;
  logic [11:0] o_y;
  logic [2:0]  o_scale;
  logic [4:0]  o_count;
  logic        o_full;
  logic        o_overflow;
  logic [7:0]  o_drop_count;
  logic        o_frame_done;
  logic [7:0]  o_frame_cand_count;

  int checks = 0;
  int errors = 0;

  face_candidate_buffer dut (
    .clk_fpga           (clk_fpga),
    .reset_fpga         (reset_fpga),
    .i_candidate        (i_candidate),
    .i_ori_x            (i_ori_x),
    .i_ori_y            (i_ori_y),
    .i_frame_end        (i_frame_end),
    .i_rd_en            (i_rd_en),
    .o_busy             (o_busy),
    .o_valid            (o_valid),
    .o_x                (o_x),
    .o_y                (o_y),
    .o_scale            (o_scale),
    .o_count            (o_count),
    .o_full             (o_full),
    .o_overflow         (o_overflow),
    .o_drop_count       (o_drop_count),
    .o_frame_done       (o_frame_done),
    .o_frame_cand_count (o_frame_cand_count)
  );

  always #5 clk_fpga = ~clk_fpga;

  typedef struct {
    int x;
    int y;
    int k;
  } ent_t;

  ent_t fq[$];
  ent_t sq[$];
  int   m_drop;
  int   m_fcnt;
  int   m_ccnt;
  bit   m_ovf;
  bit   m_pend;
  bit   m_done;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    sq.delete();
    m_drop = 0;
    m_fcnt = 0;
    m_ccnt = 0;
    m_ovf  = 0;
    m_pend = 0;
    m_done = 0;
  endtask

  task automatic step(input logic [4:0]  c,
                      input logic [11:0] x,
                      input logic [11:0] y,
                      input logic        fe,
                      input logic        rd,
                      input logic        rst);
    bit   busy0;
    bit   close;
    ent_t e;
    i_candidate = c;
    i_ori_x     = x;
    i_ori_y     = y;
    i_frame_end = fe;
    i_rd_en     = rd;
    reset_fpga  = rst;
    @(posedge clk_fpga);
    if (rst) begin
      model_reset();
    end else begin
      busy0  = (sq.size() != 0);
      close  = 0;
      m_done = 0;
      if (rd && fq.size() != 0) void'(fq.pop_front());
      if (busy0) begin
        e = sq.pop_front();
        if (fq.size() < 16) begin
          fq.push_back(e);
          if (m_fcnt < 255) m_fcnt++;
        end else begin
          m_drop = (m_drop < 255) ? m_drop + 1 : 255;
          m_ovf  = 1;
        end
        if (c != 0) begin
          m_drop = m_drop + $countones(c);
          if (m_drop > 255) m_drop = 255;
          m_ovf = 1;
        end
        if (fe) m_pend = 1;
        if (sq.size() == 0 && m_pend) close = 1;
      end else begin
        if (fe) close = 1;
        for (int k = 0; k < 5; k++) begin
          if (c[k]) begin
            e.x = int'(x);
            e.y = int'(y);
            e.k = k;
            sq.push_back(e);
          end
        end
      end
      if (close) begin
        m_done = 1;
        m_ccnt = m_fcnt;
        m_fcnt = 0;
        m_pend = 0;
      end
    end
    #1;
    chk("busy", 32'(o_busy), 32'(sq.size() != 0));
    chk("valid", 32'(o_valid), 32'(fq.size() != 0));
    chk("count", 32'(o_count), 32'(fq.size()));
    chk("full", 32'(o_full), 32'(fq.size() == 16));
    chk("overflow", 32'(o_overflow), 32'(m_ovf));
    chk("drop_count", 32'(o_drop_count), 32'(m_drop));
    chk("frame_done", 32'(o_frame_done), 32'(m_done));
    if (fq.size() != 0) begin
      chk("head_x", 32'(o_x), 32'(fq[0].x));
      chk("head_y", 32'(o_y), 32'(fq[0].y));
      chk("head_scale", 32'(o_scale), 32'(fq[0].k));
    end
    if (m_done)
      chk("frame_cnt", 32'(o_frame_cand_count), 32'(m_ccnt));
  endtask

  task automatic idle(input int n, input logic rd);
    for (int i = 0; i < n; i++) step(5'b0, 12'd0, 12'd0, 1'b0, rd, 1'b0);
  endtask

  initial begin
    logic [4:0] c;
    int         rdp;
    model_reset();
    i_candidate = '0;
    i_ori_x     = '0;
    i_ori_y     = '0;
    i_frame_end = 1'b0;
    i_rd_en     = 1'b0;
    reset_fpga  = 1'b1;

    step(5'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b1);
    step(5'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_count", 32'(o_count), 32'd0);

    // single hit
    step(5'b00100, 12'd37, 12'd9, 1'b0, 1'b0, 1'b0);
    chk("t1_pre_valid", 32'(o_valid), 32'd0);
    idle(1, 1'b0);
    chk("t1_valid", 32'(o_valid), 32'd1);
    chk("t1_x", 32'(o_x), 32'd37);
    chk("t1_y", 32'(o_y), 32'd9);
    chk("t1_scale", 32'(o_scale), 32'd2);
    idle(1, 1'b1);

    // three scales, then pop them in order
    step(5'b10101, 12'd5, 12'd3, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("t2_count", 32'(o_count), 32'd3);
    chk("t2_s0", 32'(o_scale), 32'd0);
    idle(1, 1'b1);
    chk("t2_s2", 32'(o_scale), 32'd2);
    idle(1, 1'b1);
    chk("t2_s4", 32'(o_scale), 32'd4);
    idle(1, 1'b1);

    // fill to 16 then overflow by one
    step(5'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(5'b11111, 12'(100 + i), 12'(200 + i), 1'b0, 1'b0, 1'b0);
      idle(5, 1'b0);
    end
    step(5'b00001, 12'd7, 12'd8, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("t3_full", 32'(o_full), 32'd1);
    step(5'b00001, 12'd9, 12'd9, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("t3_drop", 32'(o_drop_count), 32'd1);
    chk("t3_ovf", 32'(o_overflow), 32'd1);
    chk("t3_head", 32'(o_x), 32'd100);

    // full: push and pop on the same edge
    step(5'b00010, 12'd11, 12'd12, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b1);
    chk("t4_count", 32'(o_count), 32'd16);
    chk("t4_drop", 32'(o_drop_count), 32'd1);
    chk("t4_scale", 32'(o_scale), 32'd1);

    // frame end during SERIAL, then empty frame
    step(5'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b1);
    step(5'b00011, 12'd1, 12'd2, 1'b0, 1'b0, 1'b0);
    step(5'b0, 12'd0, 12'd0, 1'b1, 1'b0, 1'b0);
    chk("t5_not_yet", 32'(o_frame_done), 32'd0);
    idle(1, 1'b0);
    chk("t5_done", 32'(o_frame_done), 32'd1);
    chk("t5_cnt", 32'(o_frame_cand_count), 32'd2);
    step(5'b0, 12'd0, 12'd0, 1'b1, 1'b0, 1'b0);
    chk("t5_next", 32'(o_frame_cand_count), 32'd0);

    // reset while serialising
    step(5'b00111, 12'd4, 12'd4, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    step(5'b00011, 12'd6, 12'd6, 1'b0, 1'b0, 1'b0);
    step(5'b11111, 12'd0, 12'd0, 1'b0, 1'b0, 1'b0);
    step(5'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b1);
    chk("t6_busy", 32'(o_busy), 32'd0);
    chk("t6_valid", 32'(o_valid), 32'd0);
    chk("t6_ovf", 32'(o_overflow), 32'd0);

    // random traffic with varying drain rate
    for (int seg = 0; seg < 8; seg++) begin
      rdp = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 50 : 90);
      for (int i = 0; i < 120; i++) begin
        c = ($urandom_range(99) < 35) ? 5'($urandom) : 5'b0;
        step(c, 12'($urandom), 12'($urandom),
             1'($urandom_range(99) < 6),
             1'($urandom_range(99) < rdp),
             1'($urandom_range(999) < 4));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
